// File: rtl/kendall_stream.sv
// Streaming Kendall-rank front end: buffers four (x, y) samples, scores the six pairs serially
// and returns the concordant count and C-D. Optional overlap mode: KENDALL_SLIDING_WINDOW_EN.
module kendall_stream #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_conc,
  output logic [3:0]   out_tau
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e       state_q;
  logic [2:0]   cnt_q;
  logic [2:0]   p_q;
  logic [2:0]   acc_q;
  logic [W-1:0] sx_q [4];
  logic [W-1:0] sy_q [4];
  logic         out_valid_q;
  logic [2:0]   out_conc_q;
  logic [3:0]   out_tau_q;

  logic [1:0]   idx_i;
  logic [1:0]   idx_j;
  logic         pair_conc;
  logic [2:0]   acc_d;
  logic [3:0]   tau_d;

  // Pair order (0,1) (0,2) (0,3) (1,2) (1,3) (2,3) indexed by p_q.
  always_comb begin
    idx_i = 2'd0;
    idx_j = 2'd1;
    case (p_q)
      3'd0:    begin idx_i = 2'd0; idx_j = 2'd1; end
      3'd1:    begin idx_i = 2'd0; idx_j = 2'd2; end
      3'd2:    begin idx_i = 2'd0; idx_j = 2'd3; end
      3'd3:    begin idx_i = 2'd1; idx_j = 2'd2; end
      3'd4:    begin idx_i = 2'd1; idx_j = 2'd3; end
      default: begin idx_i = 2'd2; idx_j = 2'd3; end
    endcase
  end

  // Ties count as "not less" on both axes, so equal-on-both pairs are concordant.
  assign pair_conc = ((sx_q[idx_i] < sx_q[idx_j]) == (sy_q[idx_i] < sy_q[idx_j]));
  assign acc_d     = acc_q + {2'b00, pair_conc};
  assign tau_d     = {acc_d, 1'b0} - 4'd6;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = out_valid_q;
  assign out_conc  = out_conc_q;
  assign out_tau   = out_tau_q;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking would make the window shift order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= 3'd0;
      p_q         <= 3'd0;
      acc_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_conc_q  <= 3'd0;
      out_tau_q   <= 4'd0;
      // NOTE: the sample buffer is only four entries and its reset value is defined
      // behaviour, so it is reset here rather than left to power-up contents.
      for (int k = 0; k < 4; k++) begin
        sx_q[k] <= '0;
        sy_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
`ifdef KENDALL_SLIDING_WINDOW_EN
            if (cnt_q == 3'd4) begin
              sx_q[0] <= sx_q[1];
              sy_q[0] <= sy_q[1];
              sx_q[1] <= sx_q[2];
              sy_q[1] <= sy_q[2];
              sx_q[2] <= sx_q[3];
              sy_q[2] <= sy_q[3];
              sx_q[3] <= in_x;
              sy_q[3] <= in_y;
            end else begin
              sx_q[cnt_q[1:0]] <= in_x;
              sy_q[cnt_q[1:0]] <= in_y;
              cnt_q            <= cnt_q + 3'd1;
            end
`else
            sx_q[cnt_q[1:0]] <= in_x;
            sy_q[cnt_q[1:0]] <= in_y;
            cnt_q            <= cnt_q + 3'd1;
`endif
            if (cnt_q >= 3'd3) begin
              state_q <= S_CALC;
              p_q     <= 3'd0;
              acc_q   <= 3'd0;
            end
          end
        end

        S_CALC: begin
          acc_q <= acc_d;
          if (p_q == 3'd5) begin
            state_q     <= S_OUT;
            p_q         <= 3'd0;
            out_valid_q <= 1'b1;
            out_conc_q  <= acc_d;
            out_tau_q   <= tau_d;
          end else begin
            p_q <= p_q + 3'd1;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_LOAD;
            out_valid_q <= 1'b0;
`ifdef KENDALL_SLIDING_WINDOW_EN
            cnt_q       <= 3'd4;
`else
            cnt_q       <= 3'd0;
`endif
          end
        end

        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kendall_stream.sv
// Directed bench for kendall_stream: scoreboard of expected (conc, tau) pushed at stimulus time,
// popped when out_valid is seen; covers latency, ties, backpressure, mid-CALC reset.
module tb_kendall_stream;

  typedef struct {
    logic [2:0] conc;
    logic [3:0] tau;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_conc;
  logic [3:0] out_tau;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cap_cyc = 0;
  exp_t sb[$];
  logic [3:0] win_x [4];
  logic [3:0] win_y [4];

  kendall_stream #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_conc  (out_conc),
    .out_tau   (out_tau)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference result for the window currently held in win_x/win_y.
  task automatic push_expected();
    exp_t e;
    int   c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if ((win_x[i] < win_x[j]) == (win_y[i] < win_y[j])) c++;
    e.conc = 3'(c);
    e.tau  = 4'(2 * c - 6);
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y);
    bit ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("in_ready_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cap_cyc  = cyc;
  endtask

  task automatic load4(input logic [3:0] x0, y0, x1, y1, x2, y2, x3, y3, input bit push);
    win_x[0] = x0; win_y[0] = y0;
    win_x[1] = x1; win_y[1] = y1;
    win_x[2] = x2; win_y[2] = y2;
    win_x[3] = x3; win_y[3] = y3;
    if (push) push_expected();
    for (int k = 0; k < 4; k++) send(win_x[k], win_y[k]);
  endtask

  // Waits for a result, compares it with the scoreboard head, optionally stalls the
  // consumer for `hold` cycles while offering junk input, then completes the handshake.
  task automatic receive(input string tag, input int hold);
    bit   timed_out = 1'b1;
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin timed_out = 1'b0; break; end
      if (i < 6) check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
    end
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    if (timed_out) return;
    check({tag, "_latency"}, 32'(cyc - cap_cyc), 32'd6);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_conc"}, 32'(out_conc), 32'(e.conc));
    check({tag, "_tau"}, 32'(out_tau), 32'(e.tau));
    check({tag, "_out_in_ready"}, 32'(in_ready), 32'd0);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_x     = 4'hF;
      in_y     = 4'h0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_conc"}, 32'(out_conc), 32'(e.conc));
        check({tag, "_hold_tau"}, 32'(out_tau), 32'(e.tau));
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Overlap mode keeps the window after each result; restart so the next block is fresh.
  task automatic restart_window();
`ifdef KENDALL_SLIDING_WINDOW_EN
    pulse_reset();
`endif
  endtask

  initial begin
    bit saw_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_conc", 32'(out_conc), 32'd0);
    check("rst_out_tau", 32'(out_tau), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    load4(1, 1, 2, 2, 3, 3, 4, 4, 1'b1);
    receive("ascending", 0);

`ifdef KENDALL_SLIDING_WINDOW_EN
    for (int k = 0; k < 3; k++) begin
      win_x[k] = win_x[k + 1];
      win_y[k] = win_y[k + 1];
    end
    win_x[3] = 4'd0;
    win_y[3] = 4'd5;
    push_expected();
    send(4'd0, 4'd5);
    receive("slide", 0);
`endif
    restart_window();

    load4(1, 4, 2, 3, 3, 2, 4, 1, 1'b1);
    receive("descending", 0);
    restart_window();

    load4(1, 1, 2, 3, 3, 2, 4, 4, 1'b1);
    receive("one_swap", 0);
    restart_window();

    load4(5, 1, 5, 2, 5, 3, 5, 4, 1'b1);
    receive("x_ties", 0);
    restart_window();

    load4(5, 5, 5, 5, 5, 5, 5, 5, 1'b1);
    receive("all_ties", 0);
    restart_window();

    load4(3, 7, 1, 2, 9, 9, 4, 0, 1'b1);
    receive("backpressure", 10);
    restart_window();
    load4(2, 9, 8, 3, 5, 5, 1, 0, 1'b1);
    receive("after_hold", 0);
    restart_window();

    // Abort a window in the third CALC cycle; no result may appear for it.
    load4(6, 1, 2, 7, 9, 3, 0, 8, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_conc", 32'(out_conc), 32'd0);
    check("midrst_out_tau", 32'(out_tau), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_result", 32'(saw_valid), 32'd0);
    load4(4, 2, 1, 1, 3, 6, 2, 5, 1'b1);
    receive("post_reset", 0);
    restart_window();

    for (int r = 0; r < 3; r++) begin
      load4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      receive("random", 0);
      restart_window();
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kendall_stream.md
# kendall_stream

Sequential front end for the combinational Kendall-rank datapath. It accepts (x, y) samples one at a time over a valid/ready handshake and buffers a window of four points. It then evaluates the six point pairs serially, one per cycle, and returns the concordant-pair count and the signed Kendall numerator over a second valid/ready handshake. It is the producer side of the 4-point rank interface: it turns a sample stream into ranked results.

## Interface
- `W`, 4, sample component width (unsigned)
- `clk` input 1, rising-edge clock
- `rst_n` input 1, asynchronous active-low reset
- `in_valid` input 1, sample offered
- `in_ready` output 1, block can accept a sample
- `in_x` input W, sample x value
- `in_y` input W, sample y value
- `out_valid` output 1, result available
- `out_ready` input 1, consumer takes result
- `out_conc` output 3, concordant pairs, 0..6
- `out_tau` output 4, two's-complement C−D = 2·conc−6, range −6..+6

## Operation
- Storage: four (x, y) registers s0..s3, with s0 the oldest. `cnt` (0..4) holds the number of valid samples.
- FSM:
  - LOAD: `in_ready`=1. Each handshake (`in_valid`&`in_ready`) writes s[cnt] and increments `cnt`. The handshake that makes `cnt`=4 moves the FSM to CALC.
  - CALC: 6 cycles. A pair counter p=0..5 walks the pairs in the order (0,1), (0,2), (0,3), (1,2), (1,3), (2,3). The accumulator clears on entry.
  - OUT: `out_valid`=1. The handshake (`out_valid`&`out_ready`) moves the FSM to LOAD.
- Pair rule for i<j:
  - lx = (xi < xj) and ly = (yi < yj), both strict unsigned compares.
  - The pair is concordant iff lx == ly. Ties therefore compare as "not less".
- Arithmetic:
  - The 3-bit accumulator cannot exceed 6, so it never overflows.
  - `out_tau` = {conc,1'b0} − 6, truncated to 4 bits.
- Outputs `out_conc` and `out_tau` are registered and load on the CALC→OUT transition. They hold their value until the next CALC→OUT transition.
- Leaving OUT: without the sliding-window feature, `cnt` clears to 0.
- `in_valid` while `in_ready`=0 is ignored, and the data is not captured.

## Timing
- Reset: asynchronous, active while `rst_n`=0. On reset:
  - state=LOAD, `cnt`=0, s0..s3=0, p=0, accumulator=0.
  - `out_valid`=0, `out_conc`=0, `out_tau`=0.
  - `in_ready`=1 (decoded from state).
- Latency:
  - Call the cycle of the completing input handshake cycle 0.
  - CALC occupies cycles 1–6.
  - `out_valid`=1 from cycle 7.
  - `in_ready`=0 from cycle 1 through the cycle of the output handshake inclusive.
  - `in_ready`=1 the cycle after the output handshake.
- Throughput: 4 samples per result, minimum 11 cycles per result in block mode.
- Backpressure: while `out_ready`=0 in OUT, `out_valid`, `out_conc` and `out_tau` stay constant. No input is accepted.
- Reset mid-operation, in any state: all state is discarded. The partial window is lost and no `out_valid` is produced for it.
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.

## Configuration
- `KENDALL_SLIDING_WINDOW_EN` defined:
  - Leaving OUT keeps `cnt`=4.
  - In LOAD with `cnt`=4, a handshake shifts the window (s0←s1, s1←s2, s2←s3, s3←new) and enters CALC.
  - After the first window, each new sample yields one result, minimum 8 cycles per result.
- `KENDALL_SLIDING_WINDOW_EN` undefined: non-overlapping blocks of 4 samples, as described in Operation. No shift logic is synthesized.

## Test plan
- Samples (1,1), (2,2), (3,3), (4,4) with `out_ready`=1 → `out_conc`=6, `out_tau`=4'b0110, `out_valid` in cycle 7 only.
- Samples (1,4), (2,3), (3,2), (4,1) → `out_conc`=0, `out_tau`=4'b1010.
- Samples (1,1), (2,3), (3,2), (4,4) → `out_conc`=5, `out_tau`=4'b0100. Pair (1,2) is the only discordant pair.
- Ties:
  - x all 5, y = 1, 2, 3, 4 → `out_conc`=0, `out_tau`=4'b1010.
  - x all 5, y all 5 → `out_conc`=6, `out_tau`=4'b0110.
- Backpressure and reset:
  - Hold `out_ready`=0 for 10 cycles with `in_valid`=1 → outputs stable, `in_ready`=0, the next window is unaffected by the held input data.
  - Pull `rst_n` low in cycle 3 of CALC → all outputs 0, `in_ready`=1, and four fresh samples produce a correct result.
- Sliding window, macro defined: after the first case, send (0,5) → window (2,2), (3,3), (4,4), (0,5) gives `out_conc`=3, `out_tau`=4'b0000, with `out_valid` 7 cycles after the handshake.
